// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of a single-ported word memory.
// Port 0 is instruction fetch and port 1 is data/stack. Accesses that never complete are aborted with an error.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TOCNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_write,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [31:0] p0_req_wmask,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_write,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [31:0] p1_req_wmask,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,

  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_ready,

  output logic        err_sticky
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_CLR,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  localparam logic [TOCNT_W-1:0] TO_LAST = TOCNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                cmd_write_q, cmd_write_d;
  logic [31:0]         cmd_addr_q, cmd_addr_d;
  logic [31:0]         cmd_wdata_q, cmd_wdata_d;
  logic [31:0]         cmd_wmask_q, cmd_wmask_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                err_sticky_q, err_sticky_d;
  logic [TOCNT_W-1:0]  tocnt_q, tocnt_d;

  logic grant0;
  logic grant1;

  // On a tie the port that did not win last time is served, so neither requester can starve.
  assign grant0 = p0_req_valid && (!p1_req_valid || last_grant_q);
  assign grant1 = p1_req_valid && (!p0_req_valid || !last_grant_q);

  always_comb begin
    // NOTE: every variable gets its default first so no path through the case leaves it unassigned (no latches).
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_wmask_d  = cmd_wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    err_sticky_d = err_sticky_q;
    tocnt_d      = tocnt_q;

    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          cmd_write_d  = p0_req_write;
          cmd_addr_d   = p0_req_addr;
          cmd_wdata_d  = p0_req_wdata;
          cmd_wmask_d  = p0_req_wmask;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = S_START;
        end else if (grant1) begin
          cmd_write_d  = p1_req_write;
          cmd_addr_d   = p1_req_addr;
          cmd_wdata_d  = p1_req_wdata;
          cmd_wmask_d  = p1_req_wmask;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = S_START;
        end
      end
      S_START: begin
        if (mem_cmd_ready) state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        // The completion flag may still be left over from the previous access, so skip it for a cycle.
        tocnt_d = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (mem_rdata_ready) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tocnt_q == TO_LAST) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          err_sticky_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          tocnt_d = tocnt_q + TOCNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_wmask_q  <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      tocnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_wmask_q  <= cmd_wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      tocnt_q      <= tocnt_d;
    end
  end

  assign p0_req_ready  = (state_q == S_IDLE) && grant0;
  assign p1_req_ready  = (state_q == S_IDLE) && grant1;

  assign p0_resp_valid = (state_q == S_RESP) && !owner_q;
  assign p1_resp_valid = (state_q == S_RESP) &&  owner_q;
  assign p0_resp_rdata = rdata_q;
  assign p1_resp_rdata = rdata_q;
  assign p0_resp_err   = p0_resp_valid && err_q;
  assign p1_resp_err   = p1_resp_valid && err_q;

  assign mem_cmd_start = (state_q == S_START) && mem_cmd_ready;
  assign mem_cmd_write = cmd_write_q;
  assign mem_addr      = cmd_addr_q;
  assign mem_wdata     = cmd_wdata_q;
  assign mem_wmask     = cmd_wmask_q;

  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-addressed, little-endian memory model that can stall or hang.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_req_wmask;
  logic        p0_resp_valid, p0_resp_err;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_req_wmask;
  logic        p1_resp_valid, p1_resp_err;
  logic [31:0] p1_resp_rdata;
  logic        mem_cmd_start, mem_cmd_write, mem_cmd_ready;
  logic [31:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;
  logic        mem_rdata_ready;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(64), .TOCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write), .mem_cmd_ready(mem_cmd_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_ready(mem_rdata_ready),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: accepts a start when idle, completes one cycle later unless hung.
  logic [7:0]  mem_bytes [0:255];
  logic        mem_load, mem_hang, mem_block;
  logic        mem_idle, mem_pending;
  logic        m_write;
  logic [31:0] m_addr, m_wdata, m_wmask, wr_word;
  int          start_count;
  logic        last_write;
  logic [31:0] last_addr;

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return {mem_bytes[a + 8'd3], mem_bytes[a + 8'd2], mem_bytes[a + 8'd1], mem_bytes[a]};
  endfunction

  assign mem_cmd_ready = mem_idle && !mem_block;
  assign wr_word = (rd_word(m_addr[7:0]) & ~m_wmask) | (m_wdata & m_wmask);

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem_bytes[i] <= 8'h00;
      mem_bytes[0]  <= 8'h11; mem_bytes[1]  <= 8'h22; mem_bytes[2]  <= 8'h33; mem_bytes[3]  <= 8'h44;
      mem_bytes[4]  <= 8'h55; mem_bytes[5]  <= 8'h66; mem_bytes[6]  <= 8'h77; mem_bytes[7]  <= 8'h88;
      mem_bytes[8]  <= 8'h99; mem_bytes[9]  <= 8'hAA; mem_bytes[10] <= 8'hBB; mem_bytes[11] <= 8'hCC;
      mem_idle        <= 1'b1;
      mem_pending     <= 1'b0;
      mem_rdata_ready <= 1'b0;
      mem_rdata       <= 32'h0;
      start_count     <= 0;
      last_write      <= 1'b0;
      last_addr       <= 32'h0;
      m_write <= 1'b0; m_addr <= 32'h0; m_wdata <= 32'h0; m_wmask <= 32'h0;
    end else if (mem_cmd_start && mem_cmd_ready) begin
      mem_idle        <= 1'b0;
      mem_pending     <= 1'b1;
      mem_rdata_ready <= 1'b0;
      m_write         <= mem_cmd_write;
      m_addr          <= mem_addr;
      m_wdata         <= mem_wdata;
      m_wmask         <= mem_wmask;
      start_count     <= start_count + 1;
      last_write      <= mem_cmd_write;
      last_addr       <= mem_addr;
    end else if (mem_pending && !mem_hang) begin
      mem_pending     <= 1'b0;
      mem_idle        <= 1'b1;
      mem_rdata_ready <= 1'b1;
      if (m_write) begin
        for (int i = 0; i < 4; i++) mem_bytes[m_addr[7:0] + 8'(i)] <= wr_word[8*i +: 8];
      end else begin
        mem_rdata <= rd_word(m_addr[7:0]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic port_ready(input int p);
    return (p == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  function automatic logic port_resp(input int p);
    return (p == 0) ? p0_resp_valid : p1_resp_valid;
  endfunction

  task automatic drive_req(input int p, input logic v, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] wm);
    if (p == 0) begin
      p0_req_valid = v; p0_req_write = wr; p0_req_addr = a; p0_req_wdata = wd; p0_req_wmask = wm;
    end else begin
      p1_req_valid = v; p1_req_write = wr; p1_req_addr = a; p1_req_wdata = wd; p1_req_wmask = wm;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " p0_req_ready"},  p0_req_ready,  0);
    check({tag, " p1_req_ready"},  p1_req_ready,  0);
    check({tag, " p0_resp_valid"}, p0_resp_valid, 0);
    check({tag, " p1_resp_valid"}, p1_resp_valid, 0);
    check({tag, " p0_resp_rdata"}, p0_resp_rdata, 0);
    check({tag, " p1_resp_rdata"}, p1_resp_rdata, 0);
    check({tag, " p0_resp_err"},   p0_resp_err,   0);
    check({tag, " p1_resp_err"},   p1_resp_err,   0);
    check({tag, " mem_cmd_start"}, mem_cmd_start, 0);
    check({tag, " mem_cmd_write"}, mem_cmd_write, 0);
    check({tag, " mem_addr"},      mem_addr,      0);
    check({tag, " mem_wdata"},     mem_wdata,     0);
    check({tag, " mem_wmask"},     mem_wmask,     0);
    check({tag, " err_sticky"},    err_sticky,    0);
  endtask

  // Issue one request on port p and follow it to its response; latency counts cycles after the accept cycle.
  task automatic transact(input int p, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] wm, input int exp_lat, input logic chk_data,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int n;
    int lat;
    drive_req(p, 1'b1, wr, a, wd, wm);
    n = 0;
    while (!port_ready(p) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " granted"}, port_ready(p), 1);
    check({tag, " other not granted"}, port_ready(1 - p), 0);
    @(negedge clk);
    drive_req(p, 1'b0, wr, a, wd, wm);
    lat = 1;
    while (!p0_resp_valid && !p1_resp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " owner resp_valid"}, port_resp(p), 1);
    check({tag, " other resp_valid"}, port_resp(1 - p), 0);
    check({tag, " resp_err"}, (p == 0) ? p0_resp_err : p1_resp_err, exp_err);
    if (chk_data) check({tag, " resp_rdata"}, (p == 0) ? p0_resp_rdata : p1_resp_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int lat;
    int exp_port;
    int sc0;
    rst_n = 1'b0;
    mem_load = 1'b1; mem_hang = 1'b0; mem_block = 1'b0;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    transact(0, 1'b0, 32'h00, 32'h0, 32'h0, 4, 1'b1, 32'h44332211, 1'b0, "p0 read 0x00");

    transact(1, 1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, 4, 1'b0, 32'h0, 1'b0, "p1 write 0x10");
    check("write reached memory", last_write, 1);
    check("write address", last_addr, 32'h10);

    // Both ports continuously valid: grants must alternate starting with p0.
    drive_req(0, 1'b1, 1'b0, 32'h04, 32'h0, 32'h0);
    drive_req(1, 1'b1, 1'b0, 32'h08, 32'h0, 32'h0);
    for (int g = 0; g < 4; g++) begin
      exp_port = g % 2;
      n = 0;
      while (!p0_req_ready && !p1_req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rr grant %0d p0_req_ready", g), p0_req_ready, (exp_port == 0) ? 1 : 0);
      check($sformatf("rr grant %0d p1_req_ready", g), p1_req_ready, (exp_port == 1) ? 1 : 0);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!p0_resp_valid && !p1_resp_valid && lat < 100);
      check($sformatf("rr %0d latency", g), lat, 4);
      check($sformatf("rr %0d owner valid", g), port_resp(exp_port), 1);
      check($sformatf("rr %0d other valid", g), port_resp(1 - exp_port), 0);
      check($sformatf("rr %0d rdata", g), (exp_port == 0) ? p0_resp_rdata : p1_resp_rdata,
            (exp_port == 0) ? 32'h88776655 : 32'hCCBBAA99);
      if (g == 3) begin
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
      end
    end

    transact(0, 1'b0, 32'h10, 32'h0, 32'h0, 4, 1'b1, 32'hDEADBEEF, 1'b0, "p0 read 0x10");

    transact(1, 1'b1, 32'h10, 32'h00000000, 32'h0000FF00, 4, 1'b0, 32'h0, 1'b0, "p1 masked write");
    transact(0, 1'b0, 32'h10, 32'h0, 32'h0, 4, 1'b1, 32'hDEAD00EF, 1'b0, "p0 read after mask");

    // Memory busy for 10 cycles after accept: no start pulse until it is ready.
    mem_block = 1'b1;
    sc0 = start_count;
    drive_req(0, 1'b1, 1'b0, 32'h00, 32'h0, 32'h0);
    n = 0;
    while (!p0_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall granted", p0_req_ready, 1);
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("stall cycle %0d start", i), mem_cmd_start, 0);
      check($sformatf("stall cycle %0d resp", i), p0_resp_valid, 0);
      if (i < 10) @(negedge clk);
    end
    mem_block = 1'b0;
    #1;
    check("stall release start", mem_cmd_start, 1);
    @(negedge clk);
    check("stall start one pulse", mem_cmd_start, 0);
    lat = 11;
    while (!p0_resp_valid && !p1_resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("stall latency", lat, 13);
    check("stall p0 resp_valid", p0_resp_valid, 1);
    check("stall p1 resp_valid", p1_resp_valid, 0);
    check("stall rdata", p0_resp_rdata, 32'h44332211);
    check("stall start count", start_count - sc0, 1);

    // Memory never completes: abort after 64 cycles in WAIT_DONE.
    mem_hang = 1'b1;
    transact(0, 1'b0, 32'h00, 32'h0, 32'h0, 67, 1'b1, 32'h0, 1'b1, "timeout");
    check("timeout err_sticky", err_sticky, 1);
    @(negedge clk);
    check("timeout err_sticky holds", err_sticky, 1);
    mem_hang = 1'b0;
    repeat (3) @(negedge clk);
    transact(1, 1'b0, 32'h08, 32'h0, 32'h0, 4, 1'b1, 32'hCCBBAA99, 1'b0, "p1 read after timeout");
    check("err_sticky after good access", err_sticky, 1);

    // Async reset in the middle of WAIT_DONE.
    mem_hang = 1'b1;
    drive_req(0, 1'b1, 1'b0, 32'h04, 32'hA5A5A5A5, 32'hFFFF0000);
    n = 0;
    while (!p0_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre-reset granted", p0_req_ready, 1);
    @(negedge clk);
    p0_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    mem_hang = 1'b0;
    drive_req(0, 1'b1, 1'b0, 32'h00, 32'h0, 32'h0);
    drive_req(1, 1'b1, 1'b0, 32'h08, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in reset %0d p0_resp_valid", i), p0_resp_valid, 0);
      check($sformatf("in reset %0d p1_resp_valid", i), p1_resp_valid, 0);
    end
    rst_n = 1'b1;
    transact(0, 1'b0, 32'h00, 32'h0, 32'h0, 4, 1'b1, 32'h44332211, 1'b0, "post-reset p0");
    p1_req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
